serial_sub_8: RTL

// - Bit-serial subtractor computing d = a - b - bin over WIDTH clocks, one bit per cycle, LSB first.
// - Counterpart to the datapath's parallel ripple adder. It is used where an area-cheap difference
//   or compare is needed and multi-cycle latency is acceptable.
// - Operands arrive and results leave over valid/ready handshakes.
//

---
 rtl/serial_sub_8.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_sub_8.sv
// Bit-serial subtractor d = a - b - bin, one bit per clock, LSB first, with valid/ready on both sides.
// Optional signed overflow output enabled by defining SUB_OVF_EN.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// RUN    | processing one bit per clock
// DONE   | result presented, out_valid=1 until out_ready
module serial_sub_8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic w_x;
  logic w_y;
  logic w_diff;
  logic w_br_nxt;
  logic w_last;
  logic w_capture;

  assign w_x       = r_sa[0];
  assign w_y       = r_sb[0];
  assign w_diff    = w_x ^ w_y ^ r_br;
  assign w_br_nxt  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_capture = in_valid & (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result shifts in from the MSB so that after WIDTH bits it is aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_capture) begin
      r_sa  <= a;
      r_sb  <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_res <= {w_diff, r_res[WIDTH-1:1]};
      r_br  <= w_br_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign d    = r_res;
  assign bout = r_br;

`ifdef SUB_OVF_EN
  logic [1:0] r_sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sign <= 2'b00;
    else if (w_capture) r_sign <= {a[WIDTH-1], b[WIDTH-1]};
  end

  // Sign register resets to equal bits, so ovf reads 0 out of reset.
  assign ovf = (r_sign[1] != r_sign[0]) & (r_res[WIDTH-1] != r_sign[1]);
`endif

endmodule
